// File: rtl/video_timing_gen.sv
// ----------------------------------------------------------------------------
// video_timing_gen
//
// Raster timing generator for 1080p60 (default parameters) running on the
// 148.5 MHz pixel clock. It waits for the PLL lock to be stable for
// LOCK_WAIT consecutive cycles, then scans the raster and produces sync,
// data-enable, pixel coordinates and frame/line strobes. Any loss of lock
// drops straight back to the lock-qualification state, with every output
// at its idle value.
//
// All outputs are registered one cycle after the h/v counters they are
// decoded from.
//
// Optional feature (compile-time macro VTG_COLORBAR_EN):
//   defined   - rgb carries 8 vertical colour bars of width H_ACTIVE/8
//   undefined - rgb is tied to 24'h0 and no bar logic exists
//
// Ports:
//   clk       in   1   pixel clock
//   rst       in   1   synchronous active-high reset
//   pll_lock  in   1   PLL lock, synchronous to clk
//   running   out  1   high while raster timing is produced
//   hs        out  1   horizontal sync, asserted level HS_POL
//   vs        out  1   vertical sync, asserted level VS_POL
//   de        out  1   data enable, high in the active area
//   x         out  12  active pixel column, 0 outside the active area
//   y         out  12  active line, 0 outside the active area
//   sof       out  1   one-cycle strobe at pixel (0,0)
//   sol       out  1   one-cycle strobe at the start of every line
//   rgb       out  24  test-pattern pixel {R,G,B}, aligned with de
// ----------------------------------------------------------------------------
module video_timing_gen #(
    parameter int unsigned H_ACTIVE  = 1920,
    parameter int unsigned H_FP      = 88,
    parameter int unsigned H_SYNC    = 44,
    parameter int unsigned H_BP      = 148,
    parameter int unsigned V_ACTIVE  = 1080,
    parameter int unsigned V_FP      = 4,
    parameter int unsigned V_SYNC    = 5,
    parameter int unsigned V_BP      = 36,
    parameter bit          HS_POL    = 1'b1,
    parameter bit          VS_POL    = 1'b1,
    parameter int unsigned LOCK_WAIT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pll_lock,
    output logic        running,
    output logic        hs,
    output logic        vs,
    output logic        de,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        sof,
    output logic        sol,
    output logic [23:0] rgb
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] HActive    = 12'(H_ACTIVE);
    localparam logic [11:0] HSyncFirst = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HSyncLast  = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [11:0] HLast      = 12'(H_TOTAL - 1);
    localparam logic [11:0] VActive    = 12'(V_ACTIVE);
    localparam logic [11:0] VSyncFirst = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VSyncLast  = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [11:0] VLast      = 12'(V_TOTAL - 1);

    localparam int unsigned          LockW    = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
    localparam logic [LockW-1:0]     LockLast = LockW'(LOCK_WAIT - 1);

    typedef enum logic [0:0] {
        StWaitLock = 1'b0,
        StRun      = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic [LockW-1:0] lock_cnt_q, lock_cnt_d;
    logic [11:0]      h_cnt_q, h_cnt_d;
    logic [11:0]      v_cnt_q, v_cnt_d;

    logic        running_q, running_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        de_q, de_d;
    logic [11:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    logic        sof_q, sof_d;
    logic        sol_q, sol_d;

    // The raster advances only in RUN with lock still present this cycle;
    // a lock drop sampled in RUN forces idle outputs on the very next edge.
    logic run_active;
    logic h_wrap;

    assign run_active = (state_q == StRun) && pll_lock;
    assign h_wrap     = (h_cnt_q == HLast);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StWaitLock;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWaitLock: begin
                if (pll_lock && (lock_cnt_q == LockLast)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!pll_lock) begin
                    state_d = StWaitLock;
                end
            end
            default: state_d = StWaitLock;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (lock qualifier, raster counters and decode)
    // ------------------------------------------------------------------
    always_comb begin
        lock_cnt_d = '0;
        h_cnt_d    = '0;
        v_cnt_d    = '0;

        // Lock counter restarts on any low cycle; it is left at zero when
        // RUN is entered so a later loss of lock starts from scratch.
        if ((state_q == StWaitLock) && pll_lock && (lock_cnt_q != LockLast)) begin
            lock_cnt_d = lock_cnt_q + LockW'(1);
        end

        if (run_active) begin
            h_cnt_d = h_wrap ? 12'd0 : h_cnt_q + 12'd1;
            v_cnt_d = v_cnt_q;
            if (h_wrap) begin
                v_cnt_d = (v_cnt_q == VLast) ? 12'd0 : v_cnt_q + 12'd1;
            end
        end
    end

    always_comb begin
        running_d = 1'b0;
        hs_d      = ~HS_POL;
        vs_d      = ~VS_POL;
        de_d      = 1'b0;
        x_d       = '0;
        y_d       = '0;
        sof_d     = 1'b0;
        sol_d     = 1'b0;

        if (run_active) begin
            running_d = 1'b1;
            de_d      = (h_cnt_q < HActive) && (v_cnt_q < VActive);
            hs_d      = ((h_cnt_q >= HSyncFirst) && (h_cnt_q <= HSyncLast)) ? HS_POL : ~HS_POL;
            // v_cnt only moves when h_cnt wraps to 0, so vs edges fall on h_cnt=0.
            vs_d      = ((v_cnt_q >= VSyncFirst) && (v_cnt_q <= VSyncLast)) ? VS_POL : ~VS_POL;
            sof_d     = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
            sol_d     = (h_cnt_q == 12'd0);
            if (de_d) begin
                x_d = h_cnt_q;
                y_d = v_cnt_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_cnt_q <= '0;
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            running_q  <= 1'b0;
            hs_q       <= ~HS_POL;
            vs_q       <= ~VS_POL;
            de_q       <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            sof_q      <= 1'b0;
            sol_q      <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            running_q  <= running_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            de_q       <= de_d;
            x_q        <= x_d;
            y_q        <= y_d;
            sof_q      <= sof_d;
            sol_q      <= sol_d;
        end
    end

    assign running = running_q;
    assign hs      = hs_q;
    assign vs      = vs_q;
    assign de      = de_q;
    assign x       = x_q;
    assign y       = y_q;
    assign sof     = sof_q;
    assign sol     = sol_q;

`ifdef VTG_COLORBAR_EN
    // ------------------------------------------------------------------
    // Colour bars: a pixel-within-bar counter and a bar index, both kept
    // in step with h_cnt_q (zero whenever h_cnt_q is zero) so no divider
    // is needed. Columns past the eighth bar (H_ACTIVE not a multiple of
    // 8) stay on the last, black, bar.
    // ------------------------------------------------------------------
    localparam int unsigned BAR_W   = H_ACTIVE / 8;
    localparam logic [11:0] BarLast = 12'(BAR_W - 1);

    logic [11:0] bar_pix_q, bar_pix_d;
    logic [2:0]  bar_idx_q, bar_idx_d;
    logic [23:0] bar_rgb;
    logic [23:0] rgb_q, rgb_d;

    always_comb begin
        bar_pix_d = '0;
        bar_idx_d = '0;
        if (run_active && !h_wrap) begin
            if (bar_pix_q == BarLast) begin
                bar_idx_d = (bar_idx_q == 3'd7) ? 3'd7 : bar_idx_q + 3'd1;
            end else begin
                bar_pix_d = bar_pix_q + 12'd1;
                bar_idx_d = bar_idx_q;
            end
        end
    end

    always_comb begin
        bar_rgb = 24'h000000;
        unique case (bar_idx_q)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    always_comb begin
        rgb_d = de_d ? bar_rgb : 24'h000000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bar_pix_q <= '0;
            bar_idx_q <= '0;
            rgb_q     <= '0;
        end else begin
            bar_pix_q <= bar_pix_d;
            bar_idx_q <= bar_idx_d;
            rgb_q     <= rgb_d;
        end
    end

    assign rgb = rgb_q;
`else
    assign rgb = 24'h000000;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_video_timing_gen
//
// Scoreboard bench for video_timing_gen with a shrunken raster (28 x 17
// total, 16 x 8 active) so whole frames fit in a short run. The stimulus
// side drives rst/pll_lock once per cycle, advances a frame-position
// reference model and queues the outputs expected after the next edge; a
// separate monitor pops and compares them after every rising edge.
// ----------------------------------------------------------------------------
module tb_video_timing_gen;

    localparam int HA = 16, HF = 3, HSY = 4, HB = 5;
    localparam int VA = 8,  VF = 2, VSY = 3, VB = 4;
    localparam int HT = HA + HF + HSY + HB;
    localparam int VT = VA + VF + VSY + VB;
    localparam int FRAME = HT * VT;
    localparam int LW = 8;
    localparam bit HS_POL = 1'b1;
    localparam bit VS_POL = 1'b0;
    localparam int MAX_FAILS = 50;

    localparam logic [23:0] BAR_RGB [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    typedef struct packed {
        logic        running;
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] x;
        logic [11:0] y;
        logic        sof;
        logic        sol;
        logic [23:0] rgb;
    } out_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pll_lock = 1'b0;
    logic        running, hs, vs, de, sof, sol;
    logic [11:0] x, y;
    logic [23:0] rgb;

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    int exp_sof_cnt = 0;
    int dut_sof_cnt = 0;

    out_t exp_q[$];

    // Reference model state: consecutive lock cycles seen while waiting,
    // whether the raster is running, and the linear position in the frame.
    int lock_run = 0;
    bit in_run = 1'b0;
    int pos = 0;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE (HA),
        .H_FP     (HF),
        .H_SYNC   (HSY),
        .H_BP     (HB),
        .V_ACTIVE (VA),
        .V_FP     (VF),
        .V_SYNC   (VSY),
        .V_BP     (VB),
        .HS_POL   (HS_POL),
        .VS_POL   (VS_POL),
        .LOCK_WAIT(LW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pll_lock (pll_lock),
        .running  (running),
        .hs       (hs),
        .vs       (vs),
        .de       (de),
        .x        (x),
        .y        (y),
        .sof      (sof),
        .sol      (sol),
        .rgb      (rgb)
    );

    function automatic out_t idle_out();
        out_t o;
        o    = '0;
        o.hs = !HS_POL;
        o.vs = !VS_POL;
        return o;
    endfunction

    // Expected outputs for the pixel at linear frame position p.
    function automatic out_t raster_out(int p);
        out_t o;
        int h, v, bar;
        h = p % HT;
        v = p / HT;
        o         = '0;
        o.running = 1'b1;
        o.de      = (h < HA) && (v < VA);
        o.hs      = (h >= HA + HF && h < HA + HF + HSY) ? HS_POL : !HS_POL;
        o.vs      = (v >= VA + VF && v < VA + VF + VSY) ? VS_POL : !VS_POL;
        o.sof     = (p == 0);
        o.sol     = (h == 0);
        if (o.de) begin
            o.x = 12'(h);
            o.y = 12'(v);
`ifdef VTG_COLORBAR_EN
            bar = h / (HA / 8);
            if (bar > 7) bar = 7;
            o.rgb = BAR_RGB[bar];
`else
            bar = 0;
            o.rgb = 24'h0;
`endif
        end
        return o;
    endfunction

    // One clock of stimulus: drive inputs, advance the model, queue expectation.
    task automatic step(input logic r, input logic lk);
        out_t e;
        if (failures >= MAX_FAILS) return;
        @(negedge clk);
        rst      = r;
        pll_lock = lk;
        e        = idle_out();
        if (r) begin
            in_run   = 1'b0;
            lock_run = 0;
        end else if (!in_run) begin
            if (lk) begin
                lock_run++;
                if (lock_run == LW) begin
                    in_run   = 1'b1;
                    pos      = 0;
                    lock_run = 0;
                end
            end else begin
                lock_run = 0;
            end
        end else if (lk) begin
            e   = raster_out(pos);
            pos = (pos + 1) % FRAME;
        end else begin
            in_run   = 1'b0;
            lock_run = 0;
        end
        if (e.sof) exp_sof_cnt++;
        exp_q.push_back(e);
    endtask

    // Monitor: compares whatever the stimulus queued for this edge.
    always @(posedge clk) begin
        out_t e, got;
        #1;
        cycle++;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {running, hs, vs, de, x, y, sof, sol, rgb};
            if (sof === 1'b1) dut_sof_cnt++;
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL outputs cycle=%0d got run=%b hs=%b vs=%b de=%b x=%0d y=%0d sof=%b sol=%b rgb=%h expected run=%b hs=%b vs=%b de=%b x=%0d y=%0d sof=%b sol=%b rgb=%h",
                         cycle, got.running, got.hs, got.vs, got.de, got.x, got.y, got.sof,
                         got.sol, got.rgb, e.running, e.hs, e.vs, e.de, e.x, e.y, e.sof,
                         e.sol, e.rgb);
            end
        end
    end

    initial begin
        // Reset with lock already high, then hold lock for two full frames.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        for (int i = 0; i < LW + 2 * FRAME + 40; i++) step(1'b0, 1'b1);

        // Lock glitch during qualification restarts the count.
        step(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        for (int i = 0; i < LW + 20; i++) step(1'b0, 1'b1);

        // Drop lock mid-frame (line 5, pixel 10), then relock for a frame.
        for (int i = 0; i < 2 * FRAME && !(in_run && pos == 5 * HT + 10); i++) begin
            step(1'b0, 1'b1);
        end
        step(1'b0, 1'b0);
        for (int i = 0; i < LW + FRAME + 10; i++) step(1'b0, 1'b1);

        // Reset in the middle of RUN.
        for (int i = 0; i < 37; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        for (int i = 0; i < LW + 30; i++) step(1'b0, 1'b1);

        // Random lock drops and occasional resets.
        for (int i = 0; i < 6000; i++) begin
            step(($urandom_range(0, 1999) == 0), ($urandom_range(0, 149) != 0));
        end
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1);

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0 && failures < MAX_FAILS) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        checks++;
        if (dut_sof_cnt != exp_sof_cnt) begin
            failures++;
            $display("FAIL sof_count got=%0d expected=%0d", dut_sof_cnt, exp_sof_cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
